// File: rtl/md5_msg_loader.sv
// Packs software-written 32-bit words into 512-bit MD5 blocks and returns the core's digest to software.
// Latency: ack_seq follows data_seq 1 cycle after acceptance; digest_rdata follows the select 1 cycle later.
// Backpressure: blk_valid holds until blk_ready; words arriving during SEND stay unacknowledged until FILL resumes.
module md5_msg_loader #(
    parameter int WORDS_PER_BLK = 16,
    parameter int BLKCNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [31:0]                   ctrl_word,
    input  logic [31:0]                   data_word,
    input  logic [6:0]                    data_seq,
    output logic [31:0]                   status,
    output logic [6:0]                    ack_seq,
    output logic [31:0]                   digest_rdata,
    output logic [32*WORDS_PER_BLK-1:0]   blk_data,
    output logic                          blk_valid,
    output logic                          blk_last,
    input  logic                          blk_ready,
    input  logic [127:0]                  digest_in,
    input  logic                          digest_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SEND,
        S_WAIT_DIGEST,
        S_DONE
    } state_t;

    localparam logic [4:0] IDX_LAST = 5'(WORDS_PER_BLK - 1);

    state_t                state;
    state_t                state_nxt;
    logic                  start_q;
    logic [4:0]            wr_idx;
    logic [BLKCNT_W-1:0]   blk_cnt;
    logic                  done;
    logic                  overrun;
    logic [127:0]          digest;

    logic                  start_pulse;
    logic                  soft_clr;
    logic                  new_word;
    logic                  last_word;
    logic                  busy;
    logic                  blk_pending;

    logic                  begin_msg;
    logic                  accept_word;
    logic                  drop_word;
    logic                  send_fire;
    logic                  digest_cap;

    assign start_pulse = ctrl_word[0] & ~start_q;
    assign soft_clr    = ctrl_word[2];
    assign new_word    = (data_seq != ack_seq);
    assign last_word   = (wr_idx == IDX_LAST);

    assign busy        = (state == S_FILL) || (state == S_SEND) || (state == S_WAIT_DIGEST);
    assign blk_pending = (state == S_SEND) && new_word;

    assign status = {16'(blk_cnt), 7'd0, wr_idx, blk_pending, overrun, done, busy};

    // Next-state and per-cycle action strobes; soft clear overrides every state.
    always_comb begin
        state_nxt   = state;
        begin_msg   = 1'b0;
        accept_word = 1'b0;
        drop_word   = 1'b0;
        send_fire   = 1'b0;
        digest_cap  = 1'b0;

        if (soft_clr) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_pulse) begin
                        state_nxt = S_FILL;
                        begin_msg = 1'b1;
                    end
                    if (new_word) begin
                        drop_word = 1'b1;
                    end
                end
                S_FILL: begin
                    if (new_word) begin
                        accept_word = 1'b1;
                        if (last_word) begin
                            state_nxt = S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (blk_valid && blk_ready) begin
                        send_fire = 1'b1;
                        state_nxt = blk_last ? S_WAIT_DIGEST : S_FILL;
                    end
                end
                S_WAIT_DIGEST: begin
                    if (digest_valid) begin
                        digest_cap = 1'b1;
                        state_nxt  = S_DONE;
                    end
                    if (new_word) begin
                        drop_word = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_q      <= 1'b0;
            ack_seq      <= 7'd0;
            wr_idx       <= 5'd0;
            blk_cnt      <= '0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            blk_valid    <= 1'b0;
            blk_last     <= 1'b0;
            blk_data     <= '0;
            digest       <= '0;
            digest_rdata <= 32'd0;
        end else begin
            start_q <= ctrl_word[0];

            case (ctrl_word[5:4])
                2'd0:    digest_rdata <= digest[31:0];
                2'd1:    digest_rdata <= digest[63:32];
                2'd2:    digest_rdata <= digest[95:64];
                default: digest_rdata <= digest[127:96];
            endcase

            if (soft_clr) begin
                // Re-arm the tracker on the current seq so a stale word is never taken.
                ack_seq   <= data_seq;
                wr_idx    <= 5'd0;
                blk_cnt   <= '0;
                done      <= 1'b0;
                overrun   <= 1'b0;
                blk_valid <= 1'b0;
                blk_last  <= 1'b0;
                digest    <= '0;
            end else begin
                if (begin_msg) begin
                    wr_idx  <= 5'd0;
                    blk_cnt <= '0;
                    done    <= 1'b0;
                end

                if (drop_word) begin
                    ack_seq <= data_seq;
                    overrun <= 1'b1;
                end

                if (accept_word) begin
                    blk_data[32*wr_idx +: 32] <= data_word;
                    ack_seq                   <= data_seq;
                    if (last_word) begin
                        wr_idx    <= 5'd0;
                        blk_last  <= ctrl_word[1];
                        blk_valid <= 1'b1;
                    end else begin
                        wr_idx <= wr_idx + 5'd1;
                    end
                end

                if (send_fire) begin
                    blk_valid <= 1'b0;
                    blk_cnt   <= blk_cnt + 1'b1;
                end

                if (digest_cap) begin
                    digest <= digest_in;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule
